motion_controller: RTL and testbench

- Downstream of the CPU/sampler complex. Consumes its one-hot direction enables (right/left/forward/reverse) qualified by cpu_done, plus the obstacle flag.
- Drives both wheel H-bridges with PWM: pivot turns, U-turns, and three-sensor line following between nodes.
- On reaching a node, returns a single-cycle node_update pulse so the sampler can advance past/present/future node and request the next move.

---
 rtl/motion_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 tb/tb_motion_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_controller.sv
// ----------------------------------------------------------------------------
// motion_controller
//
// Purpose:
//   Executes one move per CPU command: straight line following (forward),
//   pivot turns (right/left) or a U-turn (reverse). Each move runs until the
//   next node is found under three-sensor line following. The controller
//   drives both wheel H-bridges with PWM. When a node is reached it returns a
//   one-cycle node_update pulse, so the sampler can step its node history and
//   issue the next command. An obstacle pauses the move without losing
//   progress. A line lost for too long latches a fault, which only reset
//   clears.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-low reset
//   i_cpu_done     level; direction enables are valid while high
//   i_right_en     command: pivot right at node
//   i_left_en      command: pivot left at node
//   i_forward_en   command: go straight
//   i_reverse_en   command: U-turn (pivot right, double blanking)
//   i_sensor[2:0]  {left,center,right} line sensors, 1 = on line
//   i_obstacle     obstacle present; pauses motion
//   o_node_update  one-cycle pulse on node arrival (shown with state IDLE)
//   o_motor_l_a/b  left wheel forward / reverse PWM
//   o_motor_r_a/b  right wheel forward / reverse PWM
//   o_busy         high in FOLLOW, TURN_BLANK, TURN_SEEK and PAUSE
//   o_cmd_err      one-cycle pulse after an illegal command
//   o_fault        sticky line-lost fault
//   o_state_dbg    current state: IDLE=0 FOLLOW=1 TURN_BLANK=2
//                  TURN_SEEK=3 PAUSE=4 FAULT=5
//
// Command handshake:
//   There is no ready signal. A command is taken exactly once. This happens on
//   a cycle where the FSM is IDLE, the controller is armed and i_cpu_done is
//   high; on that cycle the enables are sampled. Taking a command disarms the
//   controller, and any cycle with i_cpu_done low re-arms it. A stale
//   i_cpu_done that stays high after node_update therefore never repeats the
//   move.
// ----------------------------------------------------------------------------
module motion_controller #(
  parameter int PWM_PERIOD    = 1000,
  parameter int DUTY_FULL     = 800,
  parameter int DUTY_SLOW     = 400,
  parameter int NODE_DEBOUNCE = 50,
  parameter int TURN_BLANK    = 100000,
  parameter int LOST_LIMIT    = 500000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cpu_done,
  input  logic       i_right_en,
  input  logic       i_left_en,
  input  logic       i_forward_en,
  input  logic       i_reverse_en,
  input  logic [2:0] i_sensor,
  input  logic       i_obstacle,
  output logic       o_node_update,
  output logic       o_motor_l_a,
  output logic       o_motor_l_b,
  output logic       o_motor_r_a,
  output logic       o_motor_r_b,
  output logic       o_busy,
  output logic       o_cmd_err,
  output logic       o_fault,
  output logic [2:0] o_state_dbg
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int CW  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int CW1 = CW + 1;
  localparam int BW  = $clog2(2 * TURN_BLANK + 2);
  localparam int DW  = $clog2(NODE_DEBOUNCE + 2);
  localparam int LW  = $clog2(LOST_LIMIT + 2);

  // A duty at or above the period saturates to the period, so the
  // compare is always true and the output is constantly high.
  localparam int FULL_SAT = (DUTY_FULL >= PWM_PERIOD) ? PWM_PERIOD : DUTY_FULL;
  localparam int SLOW_SAT = (DUTY_SLOW >= PWM_PERIOD) ? PWM_PERIOD : DUTY_SLOW;

  localparam logic [CW-1:0] PWM_LAST    = CW'(PWM_PERIOD - 1);
  localparam logic [CW1-1:0] DUTY_FULL_W = CW1'(FULL_SAT);
  localparam logic [CW1-1:0] DUTY_SLOW_W = CW1'(SLOW_SAT);
  localparam logic [BW-1:0] BLANK_TURN  = BW'(TURN_BLANK);
  localparam logic [BW-1:0] BLANK_UTURN = BW'(2 * TURN_BLANK);
  localparam logic [DW-1:0] DEB_LAST    = DW'(NODE_DEBOUNCE - 1);
  localparam logic [LW-1:0] LOST_LAST   = LW'(LOST_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FOLLOW = 3'd1,
    S_TBLANK = 3'd2,
    S_TSEEK  = 3'd3,
    S_PAUSE  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Steering class used while following the line
  typedef enum logic [1:0] {
    ST_STRAIGHT   = 2'd0,
    ST_LEFT_SLOW  = 2'd1,
    ST_RIGHT_SLOW = 2'd2
  } steer_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t          r_state;
  state_t          r_ret;
  logic            r_armed;
  logic [CW-1:0]   r_pwm;
  logic [BW-1:0]   r_blank;
  logic [DW-1:0]   r_deb;
  logic [LW-1:0]   r_lost;
  steer_t          r_steer;
  logic            r_pivot_left;
  logic            r_node_update;
  logic            r_cmd_err;

  // --------------------------------------------------------------------------
  // Wires
  // --------------------------------------------------------------------------
  state_t          w_state_next;
  logic [3:0]      w_cmds;
  logic            w_one_cmd;
  logic            w_accept;
  logic            w_load_blank;
  logic            w_blank_dec;
  logic            w_clr_follow;
  logic            w_deb_inc;
  logic            w_deb_clr;
  logic            w_lost_inc;
  logic            w_lost_clr;
  logic            w_node;
  logic            w_cmd_bad;
  logic            w_enter_pause;
  steer_t          w_steer;
  logic            w_full_on;
  logic            w_slow_on;
  logic            w_l_fwd;
  logic            w_l_rev;
  logic            w_r_fwd;
  logic            w_r_rev;
  logic            w_l_slow;
  logic            w_r_slow;
  logic            w_l_drive;
  logic            w_r_drive;

  assign w_cmds    = {i_right_en, i_left_en, i_forward_en, i_reverse_en};
  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero
  assign w_one_cmd = (w_cmds != 4'd0) && ((w_cmds & (w_cmds - 4'd1)) == 4'd0);
  assign w_accept  = (r_state == S_IDLE) && r_armed && i_cpu_done;

  assign w_full_on = {1'b0, r_pwm} < DUTY_FULL_W;
  assign w_slow_on = {1'b0, r_pwm} < DUTY_SLOW_W;

  // Sensor-to-steering decode. 101 is treated as centred, and so is 111
  // (a node candidate). 000 holds the last steering.
  always_comb begin
    w_steer = r_steer;
    case (i_sensor)
      3'b010, 3'b101, 3'b111: w_steer = ST_STRAIGHT;
      3'b100, 3'b110:         w_steer = ST_LEFT_SLOW;
      3'b001, 3'b011:         w_steer = ST_RIGHT_SLOW;
      default:                w_steer = r_steer;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and counter controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_load_blank  = 1'b0;
    w_blank_dec   = 1'b0;
    w_clr_follow  = 1'b0;
    w_deb_inc     = 1'b0;
    w_deb_clr     = 1'b0;
    w_lost_inc    = 1'b0;
    w_lost_clr    = 1'b0;
    w_node        = 1'b0;
    w_cmd_bad     = 1'b0;
    w_enter_pause = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_one_cmd) begin
            w_cmd_bad = 1'b1;
          end else if (i_forward_en) begin
            w_state_next = S_FOLLOW;
            w_clr_follow = 1'b1;
          end else begin
            w_state_next = S_TBLANK;
            w_load_blank = 1'b1;
          end
        end
      end
      S_FOLLOW: begin
        // The obstacle takes priority over node and lost detection;
        // every counter stays frozen while paused.
        if (i_obstacle) begin
          w_state_next  = S_PAUSE;
          w_enter_pause = 1'b1;
        end else begin
          if (i_sensor == 3'b111) begin
            if (r_deb == DEB_LAST) begin
              w_state_next = S_IDLE;
              w_node       = 1'b1;
            end else begin
              w_deb_inc = 1'b1;
            end
          end else begin
            w_deb_clr = 1'b1;
          end
          if (i_sensor == 3'b000) begin
            if (r_lost == LOST_LAST) begin
              w_state_next = S_FAULT;
            end else begin
              w_lost_inc = 1'b1;
            end
          end else begin
            w_lost_clr = 1'b1;
          end
        end
      end
      S_TBLANK: begin
        if (i_obstacle) begin
          w_state_next  = S_PAUSE;
          w_enter_pause = 1'b1;
        end else begin
          w_blank_dec = 1'b1;
          // The loaded count equals the number of blanking cycles, so the
          // cycle that finds 1 is the last one.
          if (r_blank <= BW'(1)) begin
            w_state_next = S_TSEEK;
          end
        end
      end
      S_TSEEK: begin
        if (i_obstacle) begin
          w_state_next  = S_PAUSE;
          w_enter_pause = 1'b1;
        end else if (i_sensor == 3'b010) begin
          w_state_next = S_FOLLOW;
          w_clr_follow = 1'b1;
        end
      end
      S_PAUSE: begin
        if (!i_obstacle) begin
          w_state_next = r_ret;
        end
      end
      S_FAULT: begin
        w_state_next = S_FAULT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: PWM, arming, counters, latched move data, pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_pwm         <= '0;
      r_armed       <= 1'b1;
      r_blank       <= '0;
      r_deb         <= '0;
      r_lost        <= '0;
      r_steer       <= ST_STRAIGHT;
      r_pivot_left  <= 1'b0;
      r_ret         <= S_IDLE;
      r_node_update <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_pwm <= (r_pwm == PWM_LAST) ? '0 : r_pwm + CW'(1);

      if (!i_cpu_done) begin
        r_armed <= 1'b1;
      end else if (w_accept) begin
        r_armed <= 1'b0;
      end

      r_node_update <= w_node;
      r_cmd_err     <= w_cmd_bad;

      if (w_load_blank) begin
        r_blank      <= i_reverse_en ? BLANK_UTURN : BLANK_TURN;
        r_pivot_left <= i_left_en;
      end else if (w_blank_dec && (r_blank != '0)) begin
        r_blank <= r_blank - BW'(1);
      end

      if (w_clr_follow || w_deb_clr) begin
        r_deb <= '0;
      end else if (w_deb_inc) begin
        r_deb <= r_deb + DW'(1);
      end

      if (w_clr_follow || w_lost_clr) begin
        r_lost <= '0;
      end else if (w_lost_inc) begin
        r_lost <= r_lost + LW'(1);
      end

      if (w_clr_follow) begin
        r_steer <= ST_STRAIGHT;
      end else if (r_state == S_FOLLOW) begin
        r_steer <= w_steer;
      end

      if (w_enter_pause) begin
        r_ret <= r_state;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_l_fwd  = 1'b0;
    w_l_rev  = 1'b0;
    w_r_fwd  = 1'b0;
    w_r_rev  = 1'b0;
    w_l_slow = 1'b0;
    w_r_slow = 1'b0;
    case (r_state)
      S_FOLLOW: begin
        w_l_fwd  = 1'b1;
        w_r_fwd  = 1'b1;
        w_l_slow = (w_steer == ST_LEFT_SLOW);
        w_r_slow = (w_steer == ST_RIGHT_SLOW);
      end
      S_TBLANK, S_TSEEK: begin
        // Right turn and U-turn pivot clockwise; left turn is the mirror
        w_l_slow = 1'b1;
        w_r_slow = 1'b1;
        w_l_fwd  = !r_pivot_left;
        w_l_rev  = r_pivot_left;
        w_r_fwd  = r_pivot_left;
        w_r_rev  = !r_pivot_left;
      end
      default: begin
        w_l_fwd = 1'b0;
      end
    endcase
  end

  assign w_l_drive = w_l_slow ? w_slow_on : w_full_on;
  assign w_r_drive = w_r_slow ? w_slow_on : w_full_on;

  // Direction flags are mutually exclusive per wheel, so a and b never overlap
  assign o_motor_l_a   = w_l_fwd & w_l_drive;
  assign o_motor_l_b   = w_l_rev & w_l_drive;
  assign o_motor_r_a   = w_r_fwd & w_r_drive;
  assign o_motor_r_b   = w_r_rev & w_r_drive;
  assign o_node_update = r_node_update;
  assign o_cmd_err     = r_cmd_err;
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign o_fault       = (r_state == S_FAULT);
  assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_motion_controller.sv
// ----------------------------------------------------------------------------
// tb_motion_controller
//
// Bench for motion_controller with short blanking / lost / debounce
// parameters. A behavioural model tracks the expected mode, run lengths of
// node and no-line samples, remaining blank cycles and PWM phase. Outputs
// are compared after every clock edge. A vector table and hand-written
// sequences cover the command, turn, node, obstacle and fault cases with
// constant expectations.
// ----------------------------------------------------------------------------
module tb_motion_controller;

  localparam int P   = 1000;
  localparam int FUL = 800;
  localparam int SLO = 400;
  localparam int ND  = 50;
  localparam int TB  = 20;
  localparam int LL  = 10;

  // --------------------------------------------------------------------------
  // Clock / reset / DUT
  // --------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_done = 1'b0;
  logic       right_en = 1'b0;
  logic       left_en = 1'b0;
  logic       forward_en = 1'b0;
  logic       reverse_en = 1'b0;
  logic [2:0] sensor = 3'b010;
  logic       obstacle = 1'b0;
  logic       node_update, motor_l_a, motor_l_b, motor_r_a, motor_r_b;
  logic       busy, cmd_err, fault;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  motion_controller #(
    .PWM_PERIOD(P), .DUTY_FULL(FUL), .DUTY_SLOW(SLO),
    .NODE_DEBOUNCE(ND), .TURN_BLANK(TB), .LOST_LIMIT(LL)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_cpu_done(cpu_done),
    .i_right_en(right_en), .i_left_en(left_en),
    .i_forward_en(forward_en), .i_reverse_en(reverse_en),
    .i_sensor(sensor), .i_obstacle(obstacle),
    .o_node_update(node_update),
    .o_motor_l_a(motor_l_a), .o_motor_l_b(motor_l_b),
    .o_motor_r_a(motor_r_a), .o_motor_r_b(motor_r_b),
    .o_busy(busy), .o_cmd_err(cmd_err), .o_fault(fault),
    .o_state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  // --------------------------------------------------------------------------
  // Behavioural reference model
  // --------------------------------------------------------------------------
  int m_state = 0;   // 0 idle,1 follow,2 blank,3 seek,4 pause,5 fault
  int m_ret = 0;
  bit m_armed = 1;
  int m_pwm = 0;
  int m_blank = 0;   // blanking cycles still to run
  int m_run111 = 0;  // consecutive node samples while following
  int m_run000 = 0;  // consecutive no-line samples while following
  int m_steer = 0;   // 0 straight, 1 left slow, 2 right slow
  bit m_left = 0;
  bit m_node = 0;
  bit m_err = 0;

  function automatic int steer_of(input logic [2:0] s);
    if (s == 3'b100 || s == 3'b110) return 1;
    if (s == 3'b001 || s == 3'b011) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    int ones;
    bit taken;
    if (!reset) begin
      m_state = 0; m_ret = 0; m_armed = 1; m_pwm = 0; m_blank = 0;
      m_run111 = 0; m_run000 = 0; m_steer = 0; m_left = 0;
      m_node = 0; m_err = 0;
      return;
    end
    m_node = 0;
    m_err = 0;
    taken = 0;
    ones = int'(right_en) + int'(left_en) + int'(forward_en) + int'(reverse_en);
    case (m_state)
      0: if (m_armed && cpu_done) begin
           taken = 1;
           if (ones != 1) m_err = 1;
           else if (forward_en) begin
             m_state = 1; m_run111 = 0; m_run000 = 0; m_steer = 0;
           end else begin
             m_state = 2; m_blank = reverse_en ? 2 * TB : TB; m_left = left_en;
           end
         end
      1: begin
           if (sensor != 3'b000) m_steer = steer_of(sensor);
           if (obstacle) begin
             m_ret = 1; m_state = 4;
           end else begin
             m_run111 = (sensor == 3'b111) ? m_run111 + 1 : 0;
             m_run000 = (sensor == 3'b000) ? m_run000 + 1 : 0;
             if (m_run111 == ND) begin m_node = 1; m_state = 0; end
             else if (m_run000 == LL) m_state = 5;
           end
         end
      2: if (obstacle) begin m_ret = 2; m_state = 4; end
         else begin
           m_blank = m_blank - 1;
           if (m_blank <= 0) m_state = 3;
         end
      3: if (obstacle) begin m_ret = 3; m_state = 4; end
         else if (sensor == 3'b010) begin
           m_state = 1; m_run111 = 0; m_run000 = 0; m_steer = 0;
         end
      4: if (!obstacle) m_state = m_ret;
      default: ;
    endcase
    if (!cpu_done) m_armed = 1;
    else if (taken) m_armed = 0;
    m_pwm = (m_pwm + 1) % P;
  endtask

  // Expected {node, l_a, l_b, r_a, r_b, busy, cmd_err, fault, state[2:0]}
  function automatic logic [10:0] model_out();
    int sl, sr, dl, dr, cls;
    bit on_l, on_r;
    logic [2:0] st;
    sl = 0; sr = 0; dl = FUL; dr = FUL;
    if (m_state == 1) begin
      sl = 1; sr = 1;
      cls = (sensor == 3'b000) ? m_steer : steer_of(sensor);
      if (cls == 1) dl = SLO;
      if (cls == 2) dr = SLO;
    end else if (m_state == 2 || m_state == 3) begin
      dl = SLO; dr = SLO;
      if (m_left) begin sl = -1; sr = 1; end
      else begin sl = 1; sr = -1; end
    end
    on_l = (m_pwm < dl);
    on_r = (m_pwm < dr);
    st = 3'(m_state);
    return {m_node, (sl == 1) && on_l, (sl == -1) && on_l,
            (sr == 1) && on_r, (sr == -1) && on_r,
            (m_state >= 1) && (m_state <= 4), m_err, m_state == 5, st};
  endfunction

  function automatic logic [10:0] dut_out();
    return {node_update, motor_l_a, motor_l_b, motor_r_a, motor_r_b,
            busy, cmd_err, fault, state_dbg};
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard helpers
  // --------------------------------------------------------------------------
  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [10:0] e, a;
    @(posedge clk);
    model_edge();
    #1;
    e = model_out();
    a = dut_out();
    n_checks++;
    if (a !== e) begin
      n_errors++;
      if (n_errors <= 25)
        $display("FAIL %s @%0t: dut=%b model=%b", tag, $time, a, e);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic drive(input logic c, input logic [3:0] en,
                       input logic [2:0] s, input logic o);
    cpu_done = c;
    {right_en, left_en, forward_en, reverse_en} = en;
    sensor = s;
    obstacle = o;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) tick("reset");
    reset = 1'b1;
  endtask

  // Issue a command from a freshly re-armed IDLE
  task automatic command(input logic [3:0] en, input logic [2:0] s);
    drive(1'b0, 4'b0000, s, 1'b0);
    tick("rearm");
    drive(1'b1, en, s, 1'b0);
    tick("cmd");
  endtask

  // Count consecutive samples in the given state (bounded)
  task automatic count_state(input int st, output int cnt);
    cnt = 0;
    for (int i = 0; i < 300 && int'(state_dbg) == st; i++) begin
      cnt++;
      tick("count");
    end
  endtask

  typedef struct {
    logic       cpu;
    logic [3:0] en;     // {right,left,forward,reverse}
    logic [2:0] sen;
    logic       obs;
    int         cyc;
    logic [2:0] st;     // state expected after the cycles
  } vec_t;

  vec_t vecs[16];

  initial begin
    int cnt, la, lb, ra, rb, pulses;
    logic last_node;
    int hold_s;

    // ---------------- 1. reset, forward, PWM duty ----------------
    drive(1'b0, 4'b0000, 3'b010, 1'b0);
    do_reset(3);
    check_int("reset_state", int'(state_dbg), 0);
    check_int("reset_outputs", int'(dut_out()), 0);
    drive(1'b1, 4'b0010, 3'b010, 1'b0);
    tick("fwd_cmd");
    check_int("fwd_state", int'(state_dbg), 1);
    la = 0; lb = 0; ra = 0; rb = 0;
    for (int i = 0; i < P; i++) begin
      la += int'(motor_l_a); lb += int'(motor_l_b);
      ra += int'(motor_r_a); rb += int'(motor_r_b);
      tick("pwm");
    end
    check_int("pwm_l_a_high", la, FUL);
    check_int("pwm_r_a_high", ra, FUL);
    check_int("pwm_b_high", lb + rb, 0);

    // ---------------- 2. node arrival ----------------
    pulses = 0;
    sensor = 3'b111;
    repeat (ND - 1) begin tick("node49"); pulses += int'(node_update); end
    check_int("node_short_burst", pulses, 0);
    sensor = 3'b010;
    tick("node_gap");
    sensor = 3'b111;
    pulses = 0;
    last_node = 1'b0;
    for (int i = 0; i < ND; i++) begin
      tick("node50");
      pulses += int'(node_update);
      last_node = node_update;
    end
    check_int("node_pulses", pulses, 1);
    check_int("node_on_50th", int'(last_node), 1);
    check_int("node_state", int'(state_dbg), 0);
    check_int("node_motors", int'({motor_l_a, motor_l_b, motor_r_a, motor_r_b}), 0);
    repeat (5) tick("stale_done");
    check_int("stale_not_rerun", int'(state_dbg), 0);
    command(4'b0010, 3'b010);
    check_int("rearm_runs", int'(state_dbg), 1);

    // ---------------- 3. right turn and U-turn ----------------
    do_reset(1);
    command(4'b1000, 3'b010);
    count_state(2, cnt);
    check_int("right_blank_cycles", cnt, TB);
    check_int("right_seek_state", int'(state_dbg), 3);
    tick("seek");
    check_int("right_follow_state", int'(state_dbg), 1);
    do_reset(1);
    command(4'b0001, 3'b010);
    count_state(2, cnt);
    check_int("uturn_blank_cycles", cnt, 2 * TB);
    tick("seek");
    check_int("uturn_follow_state", int'(state_dbg), 1);
    do_reset(1);
    command(4'b0100, 3'b000);
    check_int("left_pivot_l_a", int'(motor_l_a), 0);
    check_int("left_pivot_r_b", int'(motor_r_b), 0);

    // ---------------- 4. illegal commands ----------------
    do_reset(1);
    drive(1'b0, 4'b0000, 3'b010, 1'b0);
    tick("idle");
    drive(1'b1, 4'b1100, 3'b010, 1'b0);
    pulses = 0;
    repeat (4) begin tick("bad_two"); pulses += int'(cmd_err); end
    check_int("err_two_enables", pulses, 1);
    check_int("err_two_state", int'(state_dbg), 0);
    drive(1'b0, 4'b0000, 3'b010, 1'b0);
    tick("idle");
    drive(1'b1, 4'b0000, 3'b010, 1'b0);
    pulses = 0;
    repeat (4) begin tick("bad_none"); pulses += int'(cmd_err); end
    check_int("err_no_enable", pulses, 1);
    check_int("err_motors", int'({motor_l_a, motor_l_b, motor_r_a, motor_r_b}), 0);

    // ---------------- 5. obstacle during blanking ----------------
    do_reset(1);
    command(4'b1000, 3'b000);
    repeat (TB - 7) tick("blank_pre");
    obstacle = 1'b1;
    repeat (30) tick("paused");
    check_int("pause_state", int'(state_dbg), 4);
    check_int("pause_motors", int'({motor_l_a, motor_l_b, motor_r_a, motor_r_b}), 0);
    obstacle = 1'b0;
    tick("resume");
    count_state(2, cnt);
    check_int("resume_remaining", cnt, 7);

    // ---------------- 6. line lost, reset mid-move ----------------
    do_reset(1);
    command(4'b0010, 3'b010);
    sensor = 3'b000;
    repeat (LL - 1) tick("lost");
    check_int("lost_not_yet", int'(fault), 0);
    tick("lost_last");
    check_int("lost_fault", int'(fault), 1);
    check_int("lost_state", int'(state_dbg), 5);
    do_reset(1);
    check_int("fault_reset_outputs", int'(dut_out()), 0);
    command(4'b1000, 3'b010);
    repeat (3) tick("turning");
    do_reset(1);
    check_int("midturn_reset_outputs", int'(dut_out()), 0);

    // ---------------- table-driven vectors ----------------
    vecs[0]  = '{1'b0, 4'b0000, 3'b010, 1'b0, 2,  3'd0};
    vecs[1]  = '{1'b1, 4'b0010, 3'b010, 1'b0, 1,  3'd1};
    vecs[2]  = '{1'b1, 4'b0010, 3'b100, 1'b0, 5,  3'd1};
    vecs[3]  = '{1'b0, 4'b0000, 3'b000, 1'b0, 3,  3'd1};
    vecs[4]  = '{1'b0, 4'b0000, 3'b001, 1'b0, 2,  3'd1};
    vecs[5]  = '{1'b0, 4'b0000, 3'b010, 1'b1, 4,  3'd4};
    vecs[6]  = '{1'b0, 4'b0000, 3'b010, 1'b0, 1,  3'd1};
    vecs[7]  = '{1'b0, 4'b0000, 3'b111, 1'b0, ND, 3'd0};
    vecs[8]  = '{1'b1, 4'b1100, 3'b010, 1'b0, 1,  3'd0};
    vecs[9]  = '{1'b0, 4'b0000, 3'b010, 1'b0, 1,  3'd0};
    vecs[10] = '{1'b1, 4'b1000, 3'b010, 1'b0, 1,  3'd2};
    vecs[11] = '{1'b1, 4'b1000, 3'b010, 1'b0, TB - 1, 3'd2};
    vecs[12] = '{1'b1, 4'b1000, 3'b010, 1'b0, 1,  3'd3};
    vecs[13] = '{1'b1, 4'b1000, 3'b101, 1'b0, 1,  3'd3};
    vecs[14] = '{1'b1, 4'b1000, 3'b010, 1'b0, 1,  3'd1};
    vecs[15] = '{1'b1, 4'b1000, 3'b000, 1'b0, LL, 3'd5};
    do_reset(1);
    for (int v = 0; v < 16; v++) begin
      drive(vecs[v].cpu, vecs[v].en, vecs[v].sen, vecs[v].obs);
      repeat (vecs[v].cyc) tick($sformatf("vec%0d", v));
      check_int($sformatf("vec%0d_state", v), int'(state_dbg), int'(vecs[v].st));
    end

    // ---------------- randomized stimulus against the model ----------------
    do_reset(2);
    hold_s = 0;
    for (int i = 0; i < 6000; i++) begin
      if (hold_s == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: sensor = 3'b010;
          4:          sensor = 3'b111;
          5:          sensor = 3'b100;
          6:          sensor = 3'b011;
          7:          sensor = 3'b000;
          8:          sensor = 3'b101;
          default:    sensor = 3'($urandom_range(0, 7));
        endcase
        hold_s = $urandom_range(1, 70);
      end
      hold_s--;
      if ($urandom_range(0, 7) == 0) cpu_done = ~cpu_done;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0)
          {right_en, left_en, forward_en, reverse_en} = 4'($urandom_range(0, 15));
        else
          {right_en, left_en, forward_en, reverse_en} = 4'(1 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 29) == 0) obstacle = ~obstacle;
      reset = ($urandom_range(0, 399) != 0);
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
